// File: rtl/dat_mem_pkg.sv
// -----------------------------------------------------------------------------
// dat_mem_pkg
// Shared definitions for the data memory with built-in hardware stack.
//   mem_op_t       : 3-bit operation code driven on the memory op port
//   DEF_W          : default data word width
//   DEF_DEPTH      : default number of words
//   DEF_STACK_BASE : default lowest stack address
// -----------------------------------------------------------------------------
package dat_mem_pkg;

    typedef enum logic [2:0] {
        OP_NOP   = 3'd0,
        OP_LOAD  = 3'd1,
        OP_STORE = 3'd2,
        OP_PUSH  = 3'd3,
        OP_POP   = 3'd4
    } mem_op_t;

    localparam int DEF_W          = 8;
    localparam int DEF_DEPTH      = 256;
    localparam int DEF_STACK_BASE = 192;

endpackage

// File: rtl/dat_mem_array.sv
// -----------------------------------------------------------------------------
// dat_mem_array
// Storage array with one synchronous write port and one combinational read
// port. Contents are never reset.
//   clk     : write clock
//   i_we    : write enable
//   i_waddr : write address
//   i_wdata : write data
//   i_raddr : read address
//   o_rdata : read data (combinational, shows pre-write contents)
// -----------------------------------------------------------------------------
module dat_mem_array #(
    parameter  int W     = 8,
    parameter  int DEPTH = 256,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [W-1:0]  i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [W-1:0]  o_rdata
);

    logic [W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/dat_stack_mem.sv
// -----------------------------------------------------------------------------
// dat_stack_mem
// Data memory with a single load/store port and a hardware stack living in
// [STACK_BASE, DEPTH-1]. The stack grows downward; sp points at the current
// top-of-stack word and equals DEPTH when the stack is empty.
//   clk       : clock, all state updates on the rising edge
//   reset     : asynchronous active-high reset (sp, flags, output register)
//   op        : operation (NOP/LOAD/STORE/PUSH/POP, codes 5-7 act as NOP)
//   addr      : address for LOAD/STORE
//   data_in   : write data for STORE/PUSH
//   data_out  : read data, combinational (REG_OUT=0) or registered (REG_OUT=1)
//   sp        : stack pointer
//   empty     : sp == DEPTH
//   full      : sp == STACK_BASE
//   overflow  : sticky, PUSH attempted while full
//   underflow : sticky, POP attempted while empty
// -----------------------------------------------------------------------------
module dat_stack_mem
    import dat_mem_pkg::*;
#(
    parameter  int W          = DEF_W,
    parameter  int DEPTH      = DEF_DEPTH,
    parameter  int STACK_BASE = DEF_STACK_BASE,
    parameter  int REG_OUT    = 0,
    localparam int AW         = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  mem_op_t       op,
    input  logic [AW-1:0] addr,
    input  logic [W-1:0]  data_in,
    output logic [W-1:0]  data_out,
    output logic [AW:0]   sp,
    output logic          empty,
    output logic          full,
    output logic          overflow,
    output logic          underflow
);

    localparam logic [AW:0]   SP_EMPTY = (AW+1)'(DEPTH);
    localparam logic [AW:0]   SP_FULL  = (AW+1)'(STACK_BASE);
    localparam logic [AW:0]   SP_ONE   = (AW+1)'(1);
    localparam logic [AW-1:0] A_ONE    = AW'(1);

    logic [AW:0]   r_sp;
    logic          r_overflow;
    logic          r_underflow;

    logic          w_empty;
    logic          w_full;
    logic          w_is_push;
    logic          w_is_pop;
    logic          w_push_ok;
    logic          w_pop_ok;
    logic          w_we;
    logic [AW-1:0] w_push_addr;
    logic [AW-1:0] w_waddr;
    logic [AW-1:0] w_raddr;
    logic [W-1:0]  w_rdata;
    logic [W-1:0]  w_rd;

    assign w_empty   = (r_sp == SP_EMPTY);
    assign w_full    = (r_sp == SP_FULL);
    assign w_is_push = (op == OP_PUSH);
    assign w_is_pop  = (op == OP_POP);
    assign w_push_ok = w_is_push && !w_full;
    assign w_pop_ok  = w_is_pop && !w_empty;

    // sp-1 computed on the low AW bits only: when sp == DEPTH the low bits are
    // zero and the subtraction wraps to DEPTH-1, which is the correct slot.
    assign w_push_addr = r_sp[AW-1:0] - A_ONE;

    assign w_we    = (op == OP_STORE) || w_push_ok;
    assign w_waddr = w_is_push ? w_push_addr : addr;
    assign w_raddr = w_is_pop ? r_sp[AW-1:0] : addr;

    // A POP on an empty stack would address mem[0]; force the result to zero.
    assign w_rd = (w_is_pop && w_empty) ? '0 : w_rdata;

    dat_mem_array #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_array (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (data_in),
        .i_raddr (w_raddr),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sp        <= SP_EMPTY;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_sp <= r_sp - SP_ONE;
            end else if (w_pop_ok) begin
                r_sp <= r_sp + SP_ONE;
            end
            if (w_is_push && w_full) begin
                r_overflow <= 1'b1;
            end
            if (w_is_pop && w_empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

    generate
        if (REG_OUT != 0) begin : g_reg_out
            logic [W-1:0] r_dout;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_dout <= '0;
                end else begin
                    r_dout <= w_rd;
                end
            end

            assign data_out = r_dout;
        end else begin : g_comb_out
            assign data_out = w_rd;
        end
    endgenerate

    assign sp        = r_sp;
    assign empty     = w_empty;
    assign full      = w_full;
    assign overflow  = r_overflow;
    assign underflow = r_underflow;

endmodule

// File: tb/tb_dat_stack_mem.sv
// -----------------------------------------------------------------------------
// tb_dat_stack_mem
// Directed bench driving two instances side by side: u_comb (REG_OUT=0) and
// u_reg (REG_OUT=1), both with default W/DEPTH/STACK_BASE.
// -----------------------------------------------------------------------------
module tb_dat_stack_mem;
    import dat_mem_pkg::*;

    logic       clk;
    logic       reset;
    mem_op_t    op;
    logic [7:0] addr;
    logic [7:0] data_in;

    logic [7:0] d0, d1;
    logic [8:0] sp0, sp1;
    logic       em0, em1, fu0, fu1, ov0, ov1, un0, un1;

    int n_checks = 0;
    int n_errors = 0;

    dat_stack_mem #(.REG_OUT(0)) u_comb (
        .clk(clk), .reset(reset), .op(op), .addr(addr), .data_in(data_in),
        .data_out(d0), .sp(sp0), .empty(em0), .full(fu0),
        .overflow(ov0), .underflow(un0)
    );

    dat_stack_mem #(.REG_OUT(1)) u_reg (
        .clk(clk), .reset(reset), .op(op), .addr(addr), .data_in(data_in),
        .data_out(d1), .sp(sp1), .empty(em1), .full(fu1),
        .overflow(ov1), .underflow(un1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Apply an op just after a rising edge and return at the following
    // falling edge, where this cycle's combinational outputs are stable.
    task automatic drive(input mem_op_t o, input logic [7:0] a, input logic [7:0] d);
        @(posedge clk);
        #1;
        op      = o;
        addr    = a;
        data_in = d;
        @(negedge clk);
    endtask

    // Asynchronous reset pulse placed mid-cycle, well clear of any edge.
    task automatic async_reset();
        reset = 1'b1;
        #1;
    endtask

    task automatic release_reset();
        #1;
        reset = 1'b0;
    endtask

    initial begin
        reset   = 1'b1;
        op      = OP_NOP;
        addr    = 8'h00;
        data_in = 8'h00;

        // ---- reset state ----
        #2;
        check("rst_sp0",   32'(sp0), 32'd256);
        check("rst_d1",    32'(d1),  32'h0);
        #10;
        reset = 1'b0;

        drive(OP_LOAD, 8'h00, 8'h00);
        check("init_sp",    32'(sp0), 32'd256);
        check("init_empty", 32'(em0), 32'd1);
        check("init_full",  32'(fu0), 32'd0);
        check("init_ov",    32'(ov0), 32'd0);
        check("init_un",    32'(un0), 32'd0);

        // ---- STORE / LOAD, read-during-write returns old data ----
        drive(OP_STORE, 8'h10, 8'h5A);
        drive(OP_STORE, 8'h10, 8'hA5);
        check("st_old_d0",  32'(d0), 32'h5A);
        drive(OP_LOAD, 8'h10, 8'h00);
        check("ld_d0",      32'(d0), 32'hA5);
        check("ld_d1_old",  32'(d1), 32'h5A);
        drive(OP_NOP, 8'h10, 8'h00);
        check("ld_d1",      32'(d1), 32'hA5);

        // ---- reserved op codes act as NOP ----
        drive(mem_op_t'(3'd6), 8'h10, 8'h00);
        drive(mem_op_t'(3'd5), 8'h10, 8'h00);
        drive(mem_op_t'(3'd7), 8'h10, 8'h00);
        drive(OP_LOAD, 8'h10, 8'h00);
        check("rsv_mem",    32'(d0),  32'hA5);
        check("rsv_sp",     32'(sp0), 32'd256);

        // ---- PUSH x3, check contents, POP x3 ----
        drive(OP_PUSH, 8'h00, 8'h11);
        drive(OP_PUSH, 8'h00, 8'h22);
        check("push_sp_mid", 32'(sp0), 32'd255);
        drive(OP_PUSH, 8'h00, 8'h33);
        drive(OP_LOAD, 8'hFF, 8'h00);
        check("push_sp",    32'(sp0), 32'd253);
        check("mem255",     32'(d0),  32'h11);
        check("push_empty", 32'(em0), 32'd0);
        drive(OP_LOAD, 8'hFE, 8'h00);
        check("mem254",     32'(d0),  32'h22);
        drive(OP_LOAD, 8'hFD, 8'h00);
        check("mem253",     32'(d0),  32'h33);

        drive(OP_POP, 8'h00, 8'h00);
        check("pop1_d0",    32'(d0),  32'h33);
        drive(OP_POP, 8'h00, 8'h00);
        check("pop2_d0",    32'(d0),  32'h22);
        check("pop2_d1",    32'(d1),  32'h33);
        check("pop2_sp",    32'(sp0), 32'd254);
        drive(OP_POP, 8'h00, 8'h00);
        check("pop3_d0",    32'(d0),  32'h11);
        check("pop3_d1",    32'(d1),  32'h22);
        drive(OP_NOP, 8'h00, 8'h00);
        check("pop3_d1n",   32'(d1),  32'h11);
        check("pop_sp",     32'(sp0), 32'd256);
        check("pop_sp1",    32'(sp1), 32'd256);
        check("pop_empty",  32'(em0), 32'd1);

        // ---- PUSH then POP back to back ----
        drive(OP_PUSH, 8'h00, 8'h77);
        drive(OP_POP,  8'h00, 8'h00);
        check("pp_d0",      32'(d0),  32'h77);
        drive(OP_NOP,  8'h00, 8'h00);
        check("pp_d1",      32'(d1),  32'h77);
        check("pp_sp",      32'(sp0), 32'd256);

        // ---- POP while empty ----
        drive(OP_POP, 8'h10, 8'h00);
        check("upop_d0",    32'(d0),  32'h0);
        check("upop_un_pre", 32'(un0), 32'd0);
        drive(OP_NOP, 8'h10, 8'h00);
        check("upop_d1",    32'(d1),  32'h0);
        check("upop_sp",    32'(sp0), 32'd256);
        check("upop_un",    32'(un0), 32'd1);
        check("upop_un1",   32'(un1), 32'd1);
        for (int i = 0; i < 10; i++) drive(OP_NOP, 8'h00, 8'h00);
        check("un_sticky",  32'(un0), 32'd1);
        async_reset();
        check("un_rst",     32'(un0), 32'd0);
        release_reset();

        // ---- fill the stack, then overflow ----
        drive(OP_STORE, 8'd191, 8'hEE);
        for (int i = 0; i < 64; i++) drive(OP_PUSH, 8'h00, 8'(i + 1));
        drive(OP_PUSH, 8'h00, 8'h99);
        check("fill_full",  32'(fu0), 32'd1);
        check("fill_sp",    32'(sp0), 32'd192);
        check("fill_ov_pre", 32'(ov0), 32'd0);
        drive(OP_LOAD, 8'd191, 8'h00);
        check("ovf_mem191", 32'(d0),  32'hEE);
        check("ovf_sp",     32'(sp0), 32'd192);
        check("ovf_flag",   32'(ov0), 32'd1);
        check("ovf_flag1",  32'(ov1), 32'd1);
        check("ovf_empty",  32'(em0), 32'd0);
        drive(OP_LOAD, 8'd192, 8'h00);
        check("top_word",   32'(d0),  32'h40);
        drive(OP_LOAD, 8'd255, 8'h00);
        check("bottom_word", 32'(d0), 32'h01);
        async_reset();
        check("ov_rst",     32'(ov0), 32'd0);
        check("full_rst",   32'(fu0), 32'd0);
        release_reset();

        // ---- reset mid-stream after 5 PUSHes ----
        for (int i = 0; i < 5; i++) drive(OP_PUSH, 8'h00, 8'(8'hB1 + i));
        drive(OP_NOP, 8'h00, 8'h00);
        check("mid_sp_pre", 32'(sp0), 32'd251);
        async_reset();
        check("mid_sp",     32'(sp0), 32'd256);
        check("mid_sp1",    32'(sp1), 32'd256);
        check("mid_empty",  32'(em0), 32'd1);
        check("mid_d1",     32'(d1),  32'h0);
        check("mid_ov",     32'(ov0), 32'd0);
        check("mid_un",     32'(un0), 32'd0);
        release_reset();
        drive(OP_LOAD, 8'd255, 8'h00);
        check("mid_mem255", 32'(d0),  32'hB1);
        drive(OP_LOAD, 8'd251, 8'h00);
        check("mid_mem251", 32'(d0),  32'hB5);
        check("mid_d1_ld",  32'(d1),  32'hB1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dat_stack_mem.md
# dat_stack_mem

Parametrised data memory with a single load/store port and a built-in hardware stack. The stack occupies the top region of the array and is managed by an internal stack pointer. The block replaces the fixed 8×256 data memory in the processor datapath and gives the core PUSH/POP without any ALU involvement. The block also adds sticky overflow/underflow flags and an optional registered read port.

## Interface

Parameters:
- W, 8: data word width in bits.
- DEPTH, 256: number of words; must be a power of two, at least 4.
- STACK_BASE, 192: lowest address usable by the stack; the stack occupies [STACK_BASE, DEPTH-1]; must satisfy 0 < STACK_BASE < DEPTH.
- REG_OUT, 0: 0 means a combinational read port; 1 means a registered read port with one cycle of latency.
- AW (localparam): $clog2(DEPTH).

Ports:
- clk, in, 1: the single clock; all state updates occur on its rising edge.
- reset, in, 1: asynchronous, active-high reset.
- op, in, 3: operation, of type mem_op_t.
- addr, in, AW: address for LOAD and STORE; ignored by PUSH and POP.
- data_in, in, W: write data for STORE and PUSH.
- data_out, out, W: read data.
- sp, out, AW+1: stack pointer; it points at the current top-of-stack word.
- empty, out, 1: high when sp == DEPTH.
- full, out, 1: high when sp == STACK_BASE.
- overflow, out, 1: sticky flag; set by a PUSH while full.
- underflow, out, 1: sticky flag; set by a POP while empty.

## Operation

- Reset state:
  - sp = DEPTH, so empty = 1 and full = 0.
  - overflow = 0 and underflow = 0.
  - The output register (REG_OUT=1) is 0.
  - Array contents are not reset.
- op encodings: NOP=0, LOAD=1, STORE=2, PUSH=3, POP=4. Codes 5–7 behave as NOP.
- Read value (rd):
  - POP while not empty: mem[sp[AW-1:0]].
  - POP while empty: 0.
  - All other ops: mem[addr].
- NOP and LOAD: no state change.
- STORE: mem[addr] <= data_in. STORE into the stack region is permitted, is not flagged, and does not move sp.
- PUSH while not full: mem[sp-1] <= data_in and sp <= sp-1.
- PUSH while full: no write, sp unchanged, overflow <= 1.
- POP while not empty: sp <= sp+1.
- POP while empty: sp unchanged, underflow <= 1.
- overflow and underflow are cleared only by reset.
- sp arithmetic is unsigned and AW+1 bits wide. sp never leaves the range [STACK_BASE, DEPTH], so there is no wrap-around.
- empty and full are combinational decodes of sp.

## Timing

- REG_OUT=0: data_out = rd in the same cycle, with zero latency.
  - On a STORE or PUSH cycle, data_out shows the pre-write contents.
  - The new value becomes visible from the cycle after the edge.
- REG_OUT=1: the output register captures rd at each rising edge, so data_out carries the cycle-N value during cycle N+1.
  - Read-during-write returns old data.
  - After reset, data_out = 0 until the first edge.
- Writes, sp updates and flag updates all take effect at the same rising edge.
- Back-to-back operations are allowed every cycle.
  - PUSH followed by POP returns the pushed word: combinationally in the POP cycle (REG_OUT=0), or one cycle later (REG_OUT=1).
- reset asserted mid-sequence:
  - sp, the flags and the output register clear immediately, without waiting for a clock edge.
  - Any write coinciding with the reset-asserting edge is not guaranteed; the bench must not check it.

## Structure

- Shared package dat_mem_pkg:
  - mem_op_t enum (3-bit) with OP_NOP, OP_LOAD, OP_STORE, OP_PUSH, OP_POP.
  - Default width and depth constants.
- Sub-module dat_mem_array:
  - Parametrised by W and DEPTH.
  - One synchronous write port and one combinational read port.
  - No reset.
- dat_stack_mem contains:
  - sp register and flag registers.
  - Address and write-enable muxing.
  - Optional output register, built under a generate block on REG_OUT.

## Test plan

- Reset, then a LOAD from addr 0 with default parameters -> sp=256, empty=1, full=0, overflow=0, underflow=0.
- STORE 0xA5 to addr 0x10, then LOAD from 0x10 -> data_out=0xA5. Check REG_OUT=0 (same cycle) and REG_OUT=1 (next cycle); in the STORE cycle itself, data_out shows the old value.
- PUSH 0x11, 0x22, 0x33 -> sp=253 and mem[255..253] = 11/22/33. Then POP ×3 -> data_out sequence 0x33, 0x22, 0x11, and sp returns to 256.
- POP while empty -> data_out=0, sp stays 256, underflow=1. The flag stays set through 10 subsequent NOPs and clears on reset.
- PUSH 64 words -> full=1 at sp=192. The 65th PUSH is not written (mem[191] is unchanged), sp stays 192, overflow=1.
- Assert reset mid-stream after 5 PUSHes, with no clock edge -> sp=256 and flags=0 immediately. Stored array data remains readable via LOAD.
